alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 16-bit ALU (`alu`).
- Each cycle it captures the combinational ALU result and its flags {overflow, negative, zero} through a valid/ready handshake. It then presents them to the consumer (writeback/register file) from a 2-entry skid buffer.
- It also maintains sticky flag bits and a saturating overflow-event counter for status readout.

---
 rtl/alu_result_stage.sv | 135 +++++++++++++
 tb/tb_alu_result_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered output stage behind the 16-bit ALU: 2-entry skid buffer for result/flags,
// plus sticky flag accumulation and a saturating overflow-event counter.
module alu_result_stage #(
   parameter int BW    = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BW-1:0]    in_data,
   input  logic [2:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BW-1:0]    out_data,
   output logic [2:0]       out_flags,
   input  logic             sticky_clr,
   output logic [2:0]       sticky_flags,
   output logic [CNT_W-1:0] ovf_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             r_state;
   state_t             w_next_state;
   logic [BW-1:0]      r_main_data;
   logic [2:0]         r_main_flags;
   logic [BW-1:0]      r_skid_data;
   logic [2:0]         r_skid_flags;
   logic [2:0]         r_sticky;
   logic [CNT_W-1:0]   r_ovf_count;
   logic               w_accept;
   logic               w_drain;

   assign w_accept = in_valid && in_ready;
   assign w_drain  = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         EMPTY: begin
            if (w_accept) w_next_state = ONE;
         end
         ONE: begin
            if (w_accept && !w_drain)      w_next_state = TWO;
            else if (!w_accept && w_drain) w_next_state = EMPTY;
         end
         TWO: begin
            if (w_drain) w_next_state = ONE;
         end
         default: w_next_state = EMPTY;
      endcase
   end

   // Handshakes decode registered state only, so in_ready has no path from out_ready.
   always_comb begin
      in_ready  = (r_state != TWO);
      out_valid = (r_state != EMPTY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_data  <= '0;
         r_main_flags <= '0;
         r_skid_data  <= '0;
         r_skid_flags <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_main_data  <= in_data;
                  r_main_flags <= in_flags;
               end
            end
            ONE: begin
               if (w_accept && w_drain) begin
                  r_main_data  <= in_data;
                  r_main_flags <= in_flags;
               end else if (w_accept) begin
                  r_skid_data  <= in_data;
                  r_skid_flags <= in_flags;
               end
            end
            TWO: begin
               if (w_drain) begin
                  r_main_data  <= r_skid_data;
                  r_main_flags <= r_skid_flags;
               end
            end
            default: begin
               r_main_data  <= r_main_data;
               r_main_flags <= r_main_flags;
            end
         endcase
      end
   end

   assign out_data  = r_main_data;
   assign out_flags = r_main_flags;

   // A clear coinciding with an accept restarts accumulation from that entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky    <= '0;
         r_ovf_count <= '0;
      end else if (sticky_clr) begin
         r_sticky    <= w_accept ? in_flags : 3'b000;
         r_ovf_count <= (w_accept && in_flags[2]) ? CNT_ONE : '0;
      end else if (w_accept) begin
         r_sticky <= r_sticky | in_flags;
         if (in_flags[2] && (r_ovf_count != CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + CNT_ONE;
         end
      end
   end

   assign sticky_flags = r_sticky;
   assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage with a 2-bit overflow counter
// so saturation is reachable in a handful of entries.
module tb_alu_result_stage;

   localparam int BW    = 16;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             inValid;
   logic             inReady;
   logic [BW-1:0]    inData;
   logic [2:0]       inFlags;
   logic             outValid;
   logic             outReady;
   logic [BW-1:0]    outData;
   logic [2:0]       outFlags;
   logic             stickyClr;
   logic [2:0]       stickyFlags;
   logic [CNT_W-1:0] ovfCount;

   int nVec;
   int nMiss;

   typedef struct {
      string            name;
      logic             inValid;
      logic [BW-1:0]    inData;
      logic [2:0]       inFlags;
      logic             outReady;
      logic             stickyClr;
      logic             expInReady;
      logic             expOutValid;
      logic [BW-1:0]    expOutData;
      logic [2:0]       expOutFlags;
      logic [2:0]       expSticky;
      logic [CNT_W-1:0] expOvf;
   } vec_t;

   vec_t vecs[$];

   alu_result_stage #(.BW(BW), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .in_data      (inData),
      .in_flags     (inFlags),
      .out_valid    (outValid),
      .out_ready    (outReady),
      .out_data     (outData),
      .out_flags    (outFlags),
      .sticky_clr   (stickyClr),
      .sticky_flags (stickyFlags),
      .ovf_count    (ovfCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(string name, logic iv, logic [BW-1:0] d, logic [2:0] f,
                                  logic ordy, logic clr, logic eir, logic eov,
                                  logic [BW-1:0] ed, logic [2:0] ef, logic [2:0] es,
                                  logic [CNT_W-1:0] eo);
      vec_t v;
      v.name = name;       v.inValid = iv;      v.inData = d;       v.inFlags = f;
      v.outReady = ordy;   v.stickyClr = clr;   v.expInReady = eir; v.expOutValid = eov;
      v.expOutData = ed;   v.expOutFlags = ef;  v.expSticky = es;   v.expOvf = eo;
      return v;
   endfunction

   task automatic cmpField(string name, string field, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s %s got=%0h expected=%0h", name, field, act, exp);
      end
   endtask

   task automatic checkOutput(vec_t v);
      nVec++;
      cmpField(v.name, "in_ready", 32'(inReady), 32'(v.expInReady));
      cmpField(v.name, "out_valid", 32'(outValid), 32'(v.expOutValid));
      if (v.expOutValid) begin
         cmpField(v.name, "out_data", 32'(outData), 32'(v.expOutData));
         cmpField(v.name, "out_flags", 32'(outFlags), 32'(v.expOutFlags));
      end
      cmpField(v.name, "sticky_flags", 32'(stickyFlags), 32'(v.expSticky));
      cmpField(v.name, "ovf_count", 32'(ovfCount), 32'(v.expOvf));
   endtask

   // Drive at the falling edge, let one rising edge pass, then sample 1 time unit later.
   task automatic applyStimulus(vec_t v);
      @(negedge clk);
      inValid   = v.inValid;
      inData    = v.inData;
      inFlags   = v.inFlags;
      outReady  = v.outReady;
      stickyClr = v.stickyClr;
      @(posedge clk);
      #1;
      checkOutput(v);
   endtask

   initial begin
      vec_t v;
      nVec      = 0;
      nMiss     = 0;
      rst       = 1'b1;
      inValid   = 1'b0;
      inData    = '0;
      inFlags   = '0;
      outReady  = 1'b0;
      stickyClr = 1'b0;

      #3;
      checkOutput(mkVec("reset_state", 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0));
      cmpField("reset_state", "out_data", 32'(outData), 32'h0);
      cmpField("reset_state", "out_flags", 32'(outFlags), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      //                  name            iv d         f       ordy clr  eir eov ed        ef      es      eo
      vecs.push_back(mkVec("single_load",  1, 16'h7530, 3'b000, 1,   0,   1,  1,  16'h7530, 3'b000, 3'b000, 0));
      vecs.push_back(mkVec("single_drain", 0, 16'h0000, 3'b000, 1,   0,   1,  0,  16'h0000, 3'b000, 3'b000, 0));
      vecs.push_back(mkVec("bp_first",     1, 16'h9C40, 3'b110, 0,   0,   1,  1,  16'h9C40, 3'b110, 3'b110, 1));
      vecs.push_back(mkVec("bp_second",    1, 16'h8AD0, 3'b110, 0,   0,   0,  1,  16'h9C40, 3'b110, 3'b110, 2));
      vecs.push_back(mkVec("bp_blocked",   1, 16'h1234, 3'b001, 0,   0,   0,  1,  16'h9C40, 3'b110, 3'b110, 2));
      vecs.push_back(mkVec("bp_hold",      0, 16'h0000, 3'b000, 0,   0,   0,  1,  16'h9C40, 3'b110, 3'b110, 2));
      vecs.push_back(mkVec("bp_drain1",    1, 16'h5555, 3'b001, 1,   0,   1,  1,  16'h8AD0, 3'b110, 3'b110, 2));
      vecs.push_back(mkVec("bp_drain2",    0, 16'h0000, 3'b000, 1,   0,   1,  0,  16'h0000, 3'b000, 3'b110, 2));
      vecs.push_back(mkVec("clr_idle",     0, 16'h0000, 3'b000, 1,   1,   1,  0,  16'h0000, 3'b000, 3'b000, 0));
      vecs.push_back(mkVec("ovf_1",        1, 16'h00A0, 3'b110, 1,   0,   1,  1,  16'h00A0, 3'b110, 3'b110, 1));
      vecs.push_back(mkVec("ovf_2",        1, 16'h00A1, 3'b110, 1,   0,   1,  1,  16'h00A1, 3'b110, 3'b110, 2));
      vecs.push_back(mkVec("ovf_3",        1, 16'h00A2, 3'b110, 1,   0,   1,  1,  16'h00A2, 3'b110, 3'b110, 3));
      vecs.push_back(mkVec("ovf_sat4",     1, 16'h00A3, 3'b110, 1,   0,   1,  1,  16'h00A3, 3'b110, 3'b110, 3));
      vecs.push_back(mkVec("ovf_sat5",     1, 16'h00A4, 3'b110, 1,   0,   1,  1,  16'h00A4, 3'b110, 3'b110, 3));
      vecs.push_back(mkVec("zero_flag",    1, 16'h0000, 3'b001, 1,   0,   1,  1,  16'h0000, 3'b001, 3'b111, 3));
      vecs.push_back(mkVec("clr_acc_ovf",  1, 16'h4000, 3'b100, 1,   1,   1,  1,  16'h4000, 3'b100, 3'b100, 1));
      vecs.push_back(mkVec("clr_acc_none", 1, 16'h0005, 3'b000, 1,   1,   1,  1,  16'h0005, 3'b000, 3'b000, 0));
      vecs.push_back(mkVec("pre_idle",     1, 16'h0042, 3'b110, 1,   0,   1,  1,  16'h0042, 3'b110, 3'b110, 1));

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Idle with undriven-looking data: the first cycle drains the pending entry.
      for (int i = 0; i < 10; i++) begin
         v = mkVec($sformatf("idle_%0d", i), 0, 'x, 'x, 1, 0, 1, 0, 0, 0, 3'b110, 1);
         applyStimulus(v);
      end

      // Back-to-back streaming: with out_ready=1 each entry is visible right after its accept.
      for (int i = 0; i < 16; i++) begin
         v = mkVec($sformatf("stream_%0d", i), 1, 16'(16'h0100 + i), 3'(i & 1), 1, 0,
                   1, 1, 16'(16'h0100 + i), 3'(i & 1), (i == 0) ? 3'b110 : 3'b111, 1);
         applyStimulus(v);
      end
      applyStimulus(mkVec("stream_drain", 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b111, 1));

      // Fill both entries, then assert reset between clock edges.
      applyStimulus(mkVec("rst_fill1", 1, 16'h1111, 3'b100, 0, 0, 1, 1, 16'h1111, 3'b100, 3'b111, 2));
      applyStimulus(mkVec("rst_fill2", 1, 16'h2222, 3'b100, 0, 0, 0, 1, 16'h1111, 3'b100, 3'b111, 3));
      @(negedge clk);
      inValid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput(mkVec("rst_async", 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0));
      cmpField("rst_async", "out_data", 32'(outData), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(mkVec("post_rst_load", 1, 16'h3333, 3'b000, 1, 0, 1, 1, 16'h3333, 3'b000, 3'b000, 0));
      applyStimulus(mkVec("post_rst_drain", 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
